tff_counter_sequencer: RTL and testbench
========================================

# tff_counter_sequencer

Controller that sequences a bank of WIDTH positive-edge T flip-flops as a programmable up/down counter with start/stop/pause control, terminal-count detection and optional auto-reload. It computes the per-bit toggle vector each cycle, holds the T-flip-flop state internally, and exposes both the toggle vector and the count. It serves as the standard timing/event-count engine for the behavioral project's T-flip-flop datapaths.

## Interface
- WIDTH, 8, counter and toggle-vector width (≥2)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  begin (from IDLE) or resume (from HOLD) counting
- stop  input  1  pause (from RUN) or abort (from HOLD)
- up  input  1  direction: 1 = count up 0→limit, 0 = count down limit→0; sampled only on start from IDLE
- auto  input  1  1 = auto-reload at terminal, 0 = one-shot; sampled only on start from IDLE
- limit  input  WIDTH  terminal (up) or initial (down) value; sampled only on start from IDLE
- t_vec  output  WIDTH  toggle enables applied to the flip-flop bank this cycle (combinational)
- count  output  WIDTH  current flip-flop bank value
- busy  output  1  high in RUN or HOLD
- done  output  1  one-cycle pulse, one-shot run completed
- wrap  output  1  one-cycle pulse, auto-reload occurred

## Operation
- Flip-flop bank update is strictly T-type: count_next = count ^ t_vec. Every change to count, including load and reload, goes through t_vec.
- Latched config (up_q, auto_q, limit_q) is captured on start in IDLE. Target is limit_q when up_q = 1 and 0 when up_q = 0. Reload/init value is 0 when up_q = 1 and limit_q when up_q = 0.
- States: IDLE, RUN, HOLD, DONE.
- IDLE: t_vec = 0. On start=1 with stop=0: latch config, set t_vec = count ^ init, and go to RUN.
- RUN, count ≠ target: t_vec is the counting pattern.
  - Up: t[0]=1, t[i] = &count[i-1:0].
  - Down: t[0]=1, t[i] = &~count[i-1:0].
- RUN, count = target, auto_q = 1: t_vec = count ^ init, wrap pulses, and the state stays RUN.
- RUN, count = target, auto_q = 0: t_vec = 0, go to DONE, done pulses.
- RUN with stop=1: stop has priority over terminal handling. t_vec = 0 and the state goes to HOLD.
- HOLD: t_vec = 0 and count is frozen.
  - stop=1 → IDLE (abort, count retained, no done).
  - else start=1 → RUN.
- DONE: t_vec = 0. The next cycle goes to IDLE unconditionally. count holds target.
- start and stop asserted together: stop wins in every state. In IDLE, nothing happens.
- start while in RUN or DONE is ignored. Changes to up, auto or limit outside an IDLE start are ignored.
- limit = 0, up mode: first RUN cycle is already at target, so the run is immediately one-shot done or wraps every cycle. Down mode behaves the same.
- Wrap-around: the counting pattern never passes target, so count never rolls over 2^WIDTH−1→0 except when limit = 2^WIDTH−1, where the reload produces the same value.

## Timing
- Reset values: state IDLE, count 0, up_q/auto_q/limit_q 0, done 0, wrap 0, busy 0, t_vec 0.
- Reset is asynchronous. Asserting it mid-run clears everything immediately. The first edge after deassertion behaves as IDLE.
- done and wrap are registered. Each is high for exactly one cycle, the cycle after the edge that applied the terminal decision.
- Up one-shot, start sampled at edge E0:
  - count = 0 after E0.
  - count = k after edge E0+k.
  - DONE with done = 1 after edge E0+L+1.
  - IDLE after edge E0+L+2.
- Auto-reload period is L+1 cycles, counting values 0..L (up) or L..0 (down).
- t_vec is valid combinationally in the cycle before the edge that applies it. busy is registered from the state.

## Test plan
- Reset:
  - Stimulus: assert rst low mid-RUN with count = 5.
  - Required response: count, busy, done, wrap and t_vec are 0 immediately, without waiting for a clock edge.
- Up one-shot:
  - Stimulus: WIDTH=8, limit=5, up=1, auto=0, pulse start.
  - Required response: count steps 0,1,2,3,4,5. done is high one cycle, 7 edges after start. count then holds 5 in IDLE, and busy is 0 after done.
- Down auto-reload:
  - Stimulus: limit=3, up=0, auto=1.
  - Required response: count sequence 3,2,1,0,3,2,… with wrap high for one cycle each time count returns to 3, and t_vec = 8'h03 at each reload. done never asserts.
- Pause/resume/abort:
  - Stimulus: stop at count = 2, wait 4 cycles, then start.
  - Required response: count holds 2 for 4 cycles, then resumes with 3.
  - Stimulus: a second stop while in HOLD.
  - Required response: IDLE, busy = 0, no done.
- Toggle-vector check:
  - Stimulus: up count passing 8'h07→8'h08, and 8'hFF with limit = 8'hFF, auto = 1.
  - Required response: t_vec = 8'h0F at the 8'h07→8'h08 step, and t_vec = 8'hFF at the 8'hFF reload to 0.
- Edge cases:
  - Stimulus: limit = 0 one-shot.
  - Required response: done one cycle after the start edge's RUN cycle.
  - Stimulus: start and stop asserted together in IDLE.
  - Required response: no transition.

Source files
------------

// File: rtl/tff_counter_sequencer.sv
// ---------------------------------------------------------------------------
// tff_counter_sequencer
//
// Sequences a bank of WIDTH positive-edge T flip-flops as a programmable
// up/down counter with start/stop/pause control, terminal-count detection
// and optional auto-reload. The flip-flop bank only ever updates as
// count <= count ^ t_vec, so loads and reloads are expressed as toggle
// vectors as well.
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   rst    - asynchronous, active-low reset
//   start  - begin (from IDLE) or resume (from HOLD) counting
//   stop   - pause (from RUN) or abort (from HOLD); wins over start
//   up     - direction, 1 = up 0..limit, 0 = down limit..0 (IDLE start only)
//   auto   - 1 = auto-reload at terminal, 0 = one-shot (IDLE start only)
//   limit  - terminal (up) or initial (down) value (IDLE start only)
//   t_vec  - toggle enables applied to the bank this cycle (combinational)
//   count  - current flip-flop bank value
//   busy   - high in RUN or HOLD
//   done   - one-cycle pulse, one-shot run completed
//   wrap   - one-cycle pulse, auto-reload occurred
// ---------------------------------------------------------------------------
module tff_counter_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             up,
   input  logic             auto,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] t_vec,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]       state;
   logic [1:0]       state_next;
   logic             up_q;
   logic             auto_q;
   logic [WIDTH-1:0] limit_q;

   logic [WIDTH-1:0] target;
   logic [WIDTH-1:0] init;
   logic [WIDTH-1:0] init_new;
   logic [WIDTH-1:0] count_pat;
   logic [WIDTH-1:0] t_next;
   logic             latch;
   logic             done_next;
   logic             wrap_next;

   // Terminal and reload values from the latched configuration.
   assign target   = up_q ? limit_q : '0;
   assign init     = up_q ? '0 : limit_q;
   // Initial value for a run being started right now, from the live inputs.
   assign init_new = up ? '0 : limit;

   // Counting pattern: bit i toggles when all lower bits are 1 (up) or all
   // lower bits are 0 (down); bit 0 always toggles.
   always_comb begin
      logic run_and;
      count_pat = '0;
      run_and   = 1'b1;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         count_pat[i] = run_and;
         run_and      = run_and & (up_q ? count[i] : ~count[i]);
      end
   end

   // Next-state, toggle vector and pulse decisions.
   always_comb begin
      state_next = state;
      t_next     = '0;
      latch      = 1'b0;
      done_next  = 1'b0;
      wrap_next  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && !stop) begin
               latch      = 1'b1;
               t_next     = count ^ init_new;
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            // stop takes priority over terminal handling
            if (stop) begin
               state_next = S_HOLD;
            end else if (count == target) begin
               if (auto_q) begin
                  t_next    = count ^ init;
                  wrap_next = 1'b1;
               end else begin
                  state_next = S_DONE;
                  done_next  = 1'b1;
               end
            end else begin
               t_next = count_pat;
            end
         end
         S_HOLD: begin
            if (stop) begin
               state_next = S_IDLE;
            end else if (start) begin
               state_next = S_RUN;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Held at zero while reset is asserted so the output clears immediately.
   assign t_vec = rst ? t_next : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= S_IDLE;
         count   <= '0;
         up_q    <= 1'b0;
         auto_q  <= 1'b0;
         limit_q <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         wrap    <= 1'b0;
      end else begin
         state <= state_next;
         count <= count ^ t_next;
         busy  <= (state_next == S_RUN) || (state_next == S_HOLD);
         done  <= done_next;
         wrap  <= wrap_next;
         if (latch) begin
            up_q    <= up;
            auto_q  <= auto;
            limit_q <= limit;
         end
      end
   end

endmodule

// File: tb/tb_tff_counter_sequencer.sv
// ---------------------------------------------------------------------------
// tb_tff_counter_sequencer
//
// Directed bench for tff_counter_sequencer (WIDTH = 8). Expected values are
// pushed to a scoreboard queue when stimulus is driven and popped/compared
// when the DUT output is sampled (#1 after the rising edge for registered
// outputs, mid-cycle for the combinational toggle vector).
// ---------------------------------------------------------------------------
module tb_tff_counter_sequencer;

   localparam int W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic         stop;
   logic         up;
   logic         auto;
   logic [W-1:0] limit;
   logic [W-1:0] t_vec;
   logic [W-1:0] count;
   logic         busy;
   logic         done;
   logic         wrap;

   tff_counter_sequencer #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .stop  (stop),
      .up    (up),
      .auto  (auto),
      .limit (limit),
      .t_vec (t_vec),
      .count (count),
      .busy  (busy),
      .done  (done),
      .wrap  (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        tag;
      logic [W-1:0] val;
   } sb_item_t;

   sb_item_t sb[$];
   int       vectors = 0;
   int       miscompares = 0;

   task automatic push_exp(input string tag, input logic [W-1:0] val);
      sb_item_t it;
      it.tag = tag;
      it.val = val;
      sb.push_back(it);
   endtask

   task automatic pop_chk(input string tag, input logic [W-1:0] obs);
      sb_item_t it;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
      end else begin
         it = sb.pop_front();
         assert (obs === it.val) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.val);
         end
      end
   endtask

   // One clock: expectations for the registered outputs after the edge.
   task automatic cyc(input logic [W-1:0] c, input logic b, input logic d,
                      input logic w);
      push_exp("count", c);
      push_exp("busy", {7'd0, b});
      push_exp("done", {7'd0, d});
      push_exp("wrap", {7'd0, w});
      @(posedge clk);
      #1;
      pop_chk("count", count);
      pop_chk("busy", {7'd0, busy});
      pop_chk("done", {7'd0, done});
      pop_chk("wrap", {7'd0, wrap});
   endtask

   // Combinational toggle vector for the upcoming edge.
   task automatic chk_t(input logic [W-1:0] e);
      push_exp("t_vec", e);
      #1;
      pop_chk("t_vec", t_vec);
   endtask

   function automatic logic [W-1:0] up_step(input logic [W-1:0] c);
      return c ^ (c + 8'd1);
   endfunction

   function automatic logic [W-1:0] dn_step(input logic [W-1:0] c);
      return c ^ (c - 8'd1);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; start = 1'b0; stop = 1'b0; up = 1'b0; auto = 1'b0;
      limit = '0;
      #1 rst = 1'b0;
      #1;
      push_exp("rst_count", '0); pop_chk("rst_count", count);
      push_exp("rst_busy", '0);  pop_chk("rst_busy", {7'd0, busy});
      chk_t('0);
      @(posedge clk); #1 rst = 1'b1;
      cyc(8'd0, 0, 0, 0);

      // Up one-shot, limit 5
      limit = 8'd5; up = 1'b1; auto = 1'b0; start = 1'b1;
      chk_t(8'd0);
      cyc(8'd0, 1, 0, 0);
      start = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         chk_t(up_step(8'(k - 1)));
         cyc(8'(k), 1, 0, 0);
      end
      chk_t(8'd0);
      cyc(8'd5, 0, 1, 0);
      cyc(8'd5, 0, 0, 0);
      cyc(8'd5, 0, 0, 0);

      // Down auto-reload, limit 3, from count 5
      limit = 8'd3; up = 1'b0; auto = 1'b1; start = 1'b1;
      chk_t(8'h06);
      cyc(8'd3, 1, 0, 0);
      start = 1'b0;
      for (int r = 0; r < 3; r++) begin
         for (int k = 3; k >= 1; k--) begin
            chk_t(dn_step(8'(k)));
            cyc(8'(k - 1), 1, 0, 0);
         end
         chk_t(8'h03);
         cyc(8'd3, 1, 0, 1);
      end
      // stop in RUN then stop in HOLD: abort, count retained
      stop = 1'b1;
      chk_t(8'd0);
      cyc(8'd3, 1, 0, 0);
      chk_t(8'd0);
      cyc(8'd3, 0, 0, 0);
      stop = 1'b0;
      cyc(8'd3, 0, 0, 0);

      // Pause / resume / abort, up limit 10
      limit = 8'd10; up = 1'b1; auto = 1'b0; start = 1'b1;
      chk_t(8'h03);
      cyc(8'd0, 1, 0, 0);
      start = 1'b0;
      cyc(8'd1, 1, 0, 0);
      cyc(8'd2, 1, 0, 0);
      stop = 1'b1;
      chk_t(8'd0);
      cyc(8'd2, 1, 0, 0);
      stop = 1'b0;
      // config changes outside an IDLE start are ignored
      up = 1'b0; limit = 8'd1;
      for (int k = 0; k < 4; k++) begin
         chk_t(8'd0);
         cyc(8'd2, 1, 0, 0);
      end
      start = 1'b1;
      chk_t(8'd0);
      cyc(8'd2, 1, 0, 0);
      start = 1'b0;
      chk_t(8'd1);
      cyc(8'd3, 1, 0, 0);
      stop = 1'b1;
      cyc(8'd3, 1, 0, 0);
      cyc(8'd3, 0, 0, 0);
      stop = 1'b0;
      cyc(8'd3, 0, 0, 0);

      // Toggle vector through 07 -> 08, up one-shot limit 8
      limit = 8'd8; up = 1'b1; auto = 1'b0; start = 1'b1;
      chk_t(8'h03);
      cyc(8'd0, 1, 0, 0);
      start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         if (k == 8) chk_t(8'h0F);
         else chk_t(up_step(8'(k - 1)));
         cyc(8'(k), 1, 0, 0);
      end
      cyc(8'd8, 0, 1, 0);
      cyc(8'd8, 0, 0, 0);

      // Full-range auto-reload, limit FF
      limit = 8'hFF; up = 1'b1; auto = 1'b1; start = 1'b1;
      chk_t(8'h08);
      cyc(8'd0, 1, 0, 0);
      start = 1'b0;
      for (int k = 1; k <= 255; k++) begin
         @(posedge clk); #1;
      end
      push_exp("count_ff", 8'hFF); pop_chk("count_ff", count);
      chk_t(8'hFF);
      cyc(8'd0, 1, 0, 1);
      chk_t(8'h01);
      cyc(8'd1, 1, 0, 0);
      stop = 1'b1;
      cyc(8'd1, 1, 0, 0);
      cyc(8'd1, 0, 0, 0);
      stop = 1'b0;

      // limit 0 one-shot from count 1 (up mode loads 0)
      limit = 8'd0; up = 1'b1; auto = 1'b0; start = 1'b1;
      chk_t(8'h01);
      cyc(8'd0, 1, 0, 0);
      start = 1'b0;
      chk_t(8'd0);
      cyc(8'd0, 0, 1, 0);
      cyc(8'd0, 0, 0, 0);

      // start and stop together in IDLE: nothing happens
      limit = 8'd7; up = 1'b0; auto = 1'b1; start = 1'b1; stop = 1'b1;
      chk_t(8'd0);
      cyc(8'd0, 0, 0, 0);
      cyc(8'd0, 0, 0, 0);
      start = 1'b0; stop = 1'b0;

      // Asynchronous reset mid-run at count 5
      limit = 8'd20; up = 1'b1; auto = 1'b0; start = 1'b1;
      cyc(8'd0, 1, 0, 0);
      start = 1'b0;
      for (int k = 1; k <= 5; k++) cyc(8'(k), 1, 0, 0);
      start = 1'b1;
      #2 rst = 1'b0;
      #1;
      push_exp("arst_count", '0); pop_chk("arst_count", count);
      push_exp("arst_busy", '0);  pop_chk("arst_busy", {7'd0, busy});
      push_exp("arst_done", '0);  pop_chk("arst_done", {7'd0, done});
      push_exp("arst_wrap", '0);  pop_chk("arst_wrap", {7'd0, wrap});
      push_exp("arst_t_vec", '0); pop_chk("arst_t_vec", t_vec);
      start = 1'b0;
      cyc(8'd0, 0, 0, 0);
      rst = 1'b1;
      cyc(8'd0, 0, 0, 0);
      // latched config was cleared: a fresh start uses the new inputs
      limit = 8'd2; up = 1'b0; auto = 1'b0; start = 1'b1;
      chk_t(8'h02);
      cyc(8'd2, 1, 0, 0);
      start = 1'b0;
      cyc(8'd1, 1, 0, 0);
      cyc(8'd0, 1, 0, 0);
      cyc(8'd0, 0, 1, 0);
      cyc(8'd0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
